// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// the zero word, the fetch address-error exception code and the
// default reset vector.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] ZeroWord         = 32'h0000_0000;
  localparam logic [31:0] EXC_FETCH_ADEL   = 32'h0000_0004;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

endpackage

// File: rtl/fetch_holdbuf.sv
// One-entry buffer holding a fetched word (and its PC) while the
// IF/ID register is stalled. Clear wins over load.
module fetch_holdbuf
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] held_pc,
  output logic [31:0] held_inst
);

  // Capture or drop the buffered word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= 1'b0;
      held_pc   <= ZeroWord;
      held_inst <= ZeroWord;
    end else if (clear) begin
      valid     <= 1'b0;
      held_pc   <= ZeroWord;
      held_inst <= ZeroWord;
    end else if (load) begin
      valid     <= 1'b1;
      held_pc   <= load_pc;
      held_inst <= load_inst;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the instruction bus, tracks the PC and
// feeds the IF/ID register. Optional feature macro FETCH_ALIGN_CHECK_EN
// turns misaligned PCs into a fetch exception instead of a bus request.
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_FETCH   | request high at pc, waiting for a transfer
// ST_HOLD    | word captured in hold buffer while IF/ID stalled, req low
// ST_DISCARD | flushed request still outstanding, its word is dropped
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  input  logic        if_ack_i,
  input  logic [31:0] if_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        stallreq_o,
  output logic [31:0] excepttype_o
);

  fetch_state_e state, state_next;
  logic [31:0]  pc, pc_next, pc_adv;
  logic [31:0]  redir_pc, redir_pc_next;
  logic         adv_pend, adv_pend_next;
  logic         transfer, misaligned, exc_fire;
  logic         hb_load, hb_clear, hb_valid;
  logic [31:0]  hb_pc, hb_inst;
  logic         unused_stall_bits;

  assign unused_stall_bits = ^stall[5:2];

`ifdef FETCH_ALIGN_CHECK_EN
  logic        exc_done;
  logic [31:0] exc_q;

  assign misaligned   = (state == ST_FETCH) && (pc[1:0] != 2'b00);
  assign exc_fire     = misaligned && !exc_done && !stall[1] && !flush;
  assign if_addr_o    = pc;
  assign excepttype_o = exc_q;

  // Present a misaligned-PC exception once; it re-arms only on redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_q    <= ZeroWord;
      exc_done <= 1'b0;
    end else if (flush) begin
      exc_q    <= ZeroWord;
      exc_done <= 1'b0;
    end else if (!stall[1]) begin
      exc_q <= exc_fire ? EXC_FETCH_ADEL : ZeroWord;
      if (exc_fire) exc_done <= 1'b1;
    end
  end
`else
  assign misaligned   = 1'b0;
  assign exc_fire     = 1'b0;
  assign if_addr_o    = {pc[31:2], 2'b00};
  assign excepttype_o = ZeroWord;
`endif

  // A transfer taken while stall[0] is set defers its PC step (adv_pend)
  // rather than losing it; no new request goes out until it is applied.
  assign if_req_o   = rst && (((state == ST_FETCH) && !adv_pend && !misaligned)
                              || (state == ST_DISCARD));
  assign transfer   = if_req_o && if_ack_i;
  assign stallreq_o = if_req_o && !if_ack_i;
  assign pc_adv     = branch_flag_i ? branch_target_address_i : pc + 32'd4;

  assign hb_load  = (state == ST_FETCH) && transfer && stall[1] && !flush;
  assign hb_clear = flush || ((state == ST_HOLD) && !stall[1]);

  fetch_holdbuf u_holdbuf (
    .clk       (clk),
    .rst       (rst),
    .load      (hb_load),
    .clear     (hb_clear),
    .load_pc   (pc),
    .load_inst (if_data_i),
    .valid     (hb_valid),
    .held_pc   (hb_pc),
    .held_inst (hb_inst)
  );

  // State, PC and redirect registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      redir_pc <= ZeroWord;
      adv_pend <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      redir_pc <= redir_pc_next;
      adv_pend <= adv_pend_next;
    end
  end

  // Next state and next PC; flush > stall[0] > branch > pc+4.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    redir_pc_next = redir_pc;
    adv_pend_next = adv_pend;
    case (state)
      ST_FETCH: begin
        if (flush) begin
          if (stallreq_o) begin
            state_next    = ST_DISCARD;
            redir_pc_next = new_pc;
          end else begin
            pc_next       = new_pc;
            adv_pend_next = 1'b0;
          end
        end else if (transfer) begin
          if (stall[1]) state_next = ST_HOLD;
          if (stall[0]) adv_pend_next = 1'b1;
          else          pc_next       = pc_adv;
        end else if (adv_pend && !stall[0]) begin
          pc_next       = pc_adv;
          adv_pend_next = 1'b0;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_next    = ST_FETCH;
          pc_next       = new_pc;
          adv_pend_next = 1'b0;
        end else begin
          if (!stall[1]) state_next = ST_FETCH;
          if (adv_pend && !stall[0]) begin
            pc_next       = pc_adv;
            adv_pend_next = 1'b0;
          end
        end
      end
      ST_DISCARD: begin
        if (transfer) begin
          state_next = ST_FETCH;
          pc_next    = flush ? new_pc : redir_pc;
        end else if (flush) begin
          redir_pc_next = new_pc;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // IF/ID output register: frozen by stall[1], bubbled by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o         <= ZeroWord;
      inst_o       <= ZeroWord;
      inst_valid_o <= 1'b0;
    end else if (flush) begin
      pc_o         <= ZeroWord;
      inst_o       <= ZeroWord;
      inst_valid_o <= 1'b0;
    end else if (!stall[1]) begin
      if ((state == ST_FETCH) && transfer) begin
        pc_o         <= pc;
        inst_o       <= if_data_i;
        inst_valid_o <= 1'b1;
      end else if (state == ST_HOLD) begin
        pc_o         <= hb_pc;
        inst_o       <= hb_inst;
        inst_valid_o <= hb_valid;
      end else if (exc_fire) begin
        pc_o         <= pc;
        inst_o       <= ZeroWord;
        inst_valid_o <= 1'b0;
      end else begin
        pc_o         <= ZeroWord;
        inst_o       <= ZeroWord;
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule
